// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents:
//   arb_state_e  - arbiter sequencing states (2-bit, also decoded by the controller)
//   arb_owner_e  - which port owns the access in flight
//   cnt_width()  - counter width needed to hold 0..max_val
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating starvation counter for the fetch port.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset (count -> 0)
//   inc_i    in  count one more data grant made while fetch waited
//   clr_i    in  fetch was granted; clear (wins over inc_i)
//   at_max_o out count has reached MAX; fetch must be granted next
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the IF fetch port and
// the M-stage load/store port. Each access runs IDLE -> BUSY -> RESP; data
// wins ties unless fetch has been passed over STARVE_MAX times in a row.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack)
//   if_rdata/if_ack          fetched word with one-cycle completion pulse
//   if_stall                 if_req & ~if_ack
//   d_req/d_we/d_addr/d_wdata load/store request (held until d_ack)
//   d_rdata/d_ack            load data with one-cycle completion pulse
//   d_stall                  d_req & ~d_ack
//   mem_req/we/addr/wdata    registered memory command, held until mem_ready
//   mem_rdata/mem_ready      memory response, only honoured in BUSY
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        starve_inc, starve_clr, starve_at_max;
  logic        grant_if;

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  // Fetch wins when it is alone or has been starved long enough.
  assign grant_if = if_req & (~d_req | starve_at_max);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          state_d    = ARB_BUSY;
          mem_req_d  = 1'b1;
          starve_clr = grant_if;
          starve_inc = ~grant_if & if_req;
          if (grant_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end
      end
      ARB_BUSY: begin
        // Ack is registered here so it is high for the RESP cycle only.
        if (mem_ready) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model (outstanding access,
// owner, starvation count, memory contents) is advanced once per clock and
// compared with the DUT; directed tasks add scenario-specific checks.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int unsigned vec = 0;
  int unsigned errs = 0;

  // Reference model state
  logic [31:0] mem_model [256];
  int          starve_m = 0;
  bit          busy_m = 0, resp_m = 0, own_if_m = 0, exp_we = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_if_rdata = '0, exp_d_rdata = '0;
  int          lat_left = 0;
  int          lat_cfg = -1;   // -1: random memory latency
  bit          idle_noise = 0; // stray mem_ready while no access is outstanding

  // One clock: memory responder before the edge, model update and checks after.
  task automatic tick();
    bit rst_s, if_s, d_s, dwe_s, rdy_s, prev_resp, gi;
    logic [31:0] ia_s, da_s, dw_s, rd_s;
    rdy_s = 0;
    if (busy_m) begin
      if (lat_left <= 0) rdy_s = 1;
      else lat_left--;
    end else if (idle_noise && $urandom_range(0, 1) == 1) begin
      rdy_s = 1;
    end
    mem_ready = rdy_s;
    mem_rdata = (busy_m && rdy_s) ? mem_model[mem_addr[9:2]] : $urandom();
    rst_s = rst; if_s = if_req; d_s = d_req; dwe_s = d_we;
    ia_s = if_addr; da_s = d_addr; dw_s = d_wdata; rd_s = mem_rdata;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    prev_resp = resp_m;
    resp_m = 0;
    if (rst_s) begin
      busy_m = 0; starve_m = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    end else if (busy_m) begin
      if (rdy_s) begin
        busy_m = 0; resp_m = 1;
        if (own_if_m) exp_if_rdata = rd_s;
        else if (exp_we) mem_model[exp_addr[9:2]] = exp_wdata;
        else exp_d_rdata = rd_s;
      end
    end else if (!prev_resp && (if_s || d_s)) begin
      gi = if_s && (!d_s || starve_m == SMAX);
      own_if_m = gi;
      busy_m = 1;
      lat_left = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
      if (gi) begin
        starve_m = 0; exp_addr = ia_s; exp_we = 0;
      end else begin
        if (if_s && starve_m < SMAX) starve_m++;
        exp_addr = da_s; exp_we = dwe_s; exp_wdata = dw_s;
      end
    end
    vec++;
    if (mem_req !== busy_m) begin
      errs++; $display("FAIL mem_req: got %b want %b", mem_req, busy_m);
    end
    if (busy_m) begin
      vec++;
      if (mem_addr !== exp_addr || mem_we !== exp_we) begin
        errs++;
        $display("FAIL mem_cmd: got addr=%h we=%b want addr=%h we=%b", mem_addr, mem_we, exp_addr, exp_we);
      end
      if (!own_if_m && exp_we) begin
        vec++;
        if (mem_wdata !== exp_wdata) begin
          errs++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, exp_wdata);
        end
      end
    end
    vec++;
    if (if_ack !== (resp_m && own_if_m) || d_ack !== (resp_m && !own_if_m)) begin
      errs++;
      $display("FAIL acks: got if=%b d=%b want if=%b d=%b", if_ack, d_ack, resp_m && own_if_m, resp_m && !own_if_m);
    end
    vec++;
    if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
      errs++;
      $display("FAIL rdata: got if=%h d=%h want if=%h d=%h", if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
    end
    vec++;
    if (if_stall !== (if_req & ~if_ack) || d_stall !== (d_req & ~d_ack)) begin
      errs++;
      $display("FAIL stall: got if=%b d=%b want if=%b d=%b", if_stall, d_stall, if_req & ~if_ack, d_req & ~d_ack);
    end
  endtask

  task automatic drive_random();
    if (if_ack) if_req = 1'b0;
    if (d_ack) d_req = 1'b0;
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1;
      if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    vec++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errs++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    vec++;
    if (if_ack !== 1'b0 || d_ack !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_resp: got ack=%b/%b rdata=%h/%h want all 0", if_ack, d_ack, if_rdata, d_rdata);
    end
    tick();
  endtask

  task automatic test_fetch();
    mem_model[8'h10] = 32'h00500093;
    lat_cfg = 0;
    if_addr = 32'h40; if_req = 1'b1;
    tick();
    vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errs++; $display("FAIL fetch_c1: got req=%b addr=%h we=%b want 1 00000040 0", mem_req, mem_addr, mem_we);
    end
    tick();
    vec++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h00500093 || if_stall !== 1'b0) begin
      errs++; $display("FAIL fetch_c2: got ack=%b rdata=%h stall=%b want 1 00500093 0", if_ack, if_rdata, if_stall);
    end
    if_req = 1'b0;
    tick();
    lat_cfg = -1;
  endtask

  task automatic test_store();
    lat_cfg = 2;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vec++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF || d_ack !== 1'b0) begin
        errs++;
        $display("FAIL store_busy%0d: got req=%b we=%b addr=%h wdata=%h ack=%b want 1 1 00000100 deadbeef 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, d_ack);
      end
    end
    tick();
    // Nothing has loaded since reset, so d_rdata must still read zero.
    vec++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h0 || if_ack !== 1'b0) begin
      errs++; $display("FAIL store_ack: got d_ack=%b d_rdata=%h if_ack=%b want 1 00000000 0", d_ack, d_rdata, if_ack);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    lat_cfg = -1;
  endtask

  task automatic test_collide();
    mem_model[8'h80] = 32'hA5A50001;
    mem_model[8'h11] = 32'h00000013;
    lat_cfg = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    vec++;
    if (mem_addr !== 32'h200 || mem_we !== 1'b0 || if_stall !== 1'b1 || d_stall !== 1'b1) begin
      errs++; $display("FAIL collide_c1: got addr=%h we=%b stall=%b/%b want 00000200 0 1/1", mem_addr, mem_we, if_stall, d_stall);
    end
    tick();
    vec++;
    if (d_ack !== 1'b1 || d_rdata !== 32'hA5A50001 || if_ack !== 1'b0 || if_stall !== 1'b1) begin
      errs++; $display("FAIL collide_c2: got d_ack=%b d_rdata=%h if_ack=%b if_stall=%b want 1 a5a50001 0 1", d_ack, d_rdata, if_ack, if_stall);
    end
    d_req = 1'b0;
    for (int c = 0; c < 6 && !if_ack; c++) begin
      tick();
      if (!if_ack) begin
        vec++;
        if (if_stall !== 1'b1) begin
          errs++; $display("FAIL collide_stall: got %b want 1", if_stall);
        end
      end
    end
    vec++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h00000013) begin
      errs++; $display("FAIL collide_if: got ack=%b rdata=%h want 1 00000013", if_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
    lat_cfg = -1;
  endtask

  task automatic test_starve();
    int dcnt = 0;
    int ifg = 0;
    bit prev = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C0;
    if_req = 1'b1; if_addr = 32'h0C0;
    for (int c = 0; c < 120 && ifg < 2; c++) begin
      tick();
      if (mem_req && !prev) begin
        if (mem_addr === 32'h0C0) begin
          vec++;
          if (dcnt != SMAX) begin
            errs++; $display("FAIL starve_run: got %0d data grants before fetch want %0d", dcnt, SMAX);
          end
          ifg++;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end
      prev = mem_req;
    end
    vec++;
    if (ifg != 2) begin
      errs++; $display("FAIL starve_timeout: got %0d fetch grants want 2", ifg);
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_idle_ready();
    idle_noise = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      vec++;
      if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
        errs++; $display("FAIL idle_ready: got ack=%b/%b req=%b want 0/0 0", if_ack, d_ack, mem_req);
      end
    end
    idle_noise = 0;
  endtask

  task automatic test_reset_mid_busy();
    lat_cfg = 20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick(); tick();
    vec++;
    if (mem_req !== 1'b1) begin
      errs++; $display("FAIL rst_pre: got mem_req=%b want 1", mem_req);
    end
    rst = 1'b1;
    tick();
    vec++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      errs++; $display("FAIL rst_mid: got req=%b ack=%b/%b want 0 0/0", mem_req, if_ack, d_ack);
    end
    tick();
    d_req = 1'b0; rst = 1'b0; lat_cfg = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vec++;
      if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
        errs++; $display("FAIL rst_post: got ack=%b/%b req=%b want 0/0 0", if_ack, d_ack, mem_req);
      end
    end
  endtask

  task automatic test_random();
    idle_noise = 1;
    for (int c = 0; c < 600; c++) begin
      drive_random();
      tick();
    end
    if (if_ack) if_req = 1'b0;
    if (d_ack) d_req = 1'b0;
    idle_noise = 0;
    for (int c = 0; c < 20 && (if_req || d_req || mem_req); c++) begin
      if (if_ack) if_req = 1'b0;
      if (d_ack) d_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom();
    test_reset();
    test_fetch();
    test_store();
    test_collide();
    test_starve();
    test_idle_ready();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
